// File: rtl/cb_desegment.sv
// cb_desegment: strips filler, forwards payload bits, checks CRC-24B per block; CB_DESEG_STATS_EN adds block/CRC-error counters
module cb_desegment #(
  parameter int CNT_W   = 13,
  parameter int K_LARGE = 6144,
  parameter int K_SMALL = 1056
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_start,
  input  logic in_block_size,
  input  logic in_req_crc,
  input  logic in_valid,
  input  logic in_data,
  input  logic in_filling,
  input  logic in_crc,
  output logic in_ready,
  input  logic out_full,
  output logic out_wreq,
  output logic out_data,
  output logic blk_done,
  output logic crc_ok,
  output logic err_proto
`ifdef CB_DESEG_STATS_EN
  ,
  output logic [15:0] blk_cnt,
  output logic [15:0] crc_err_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, FILL, DATA, CHECK, DONE} state_t;
  localparam logic [23:0] POLY = 24'h800063;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_dec, k_sel;
  logic [23:0] lfsr, lfsr_nx;
  logic req_q, acc, wr, feed, bad;
  assign k_sel = in_block_size ? CNT_W'(K_LARGE) : CNT_W'(K_SMALL);
  assign cnt_dec = (cnt == '0) ? '0 : cnt - CNT_W'(1);
  assign in_ready = (state == FILL || state == DATA || state == CHECK) & ~out_full;
  assign acc = in_valid & in_ready;
  assign wr = acc & ((state == DATA) | ((state == FILL) & ~in_filling));
  assign feed = wr | (acc & (state == CHECK));
  assign lfsr_nx = {lfsr[22:0], 1'b0} ^ ({24{lfsr[23] ^ in_data}} & POLY);
  assign bad = acc & ((in_filling & (state != FILL)) | (in_crc != (state == CHECK)));
  assign blk_done = (state == DONE);
  assign crc_ok = blk_done & ((lfsr == '0) | ~req_q);
  always_comb begin
    state_nx = state;
    if (in_start) state_nx = FILL;
    else
      case (state)
        FILL:    if (acc) state_nx = (cnt_dec == '0) ? DONE : in_filling ? FILL :
                                     (req_q && cnt_dec == CNT_W'(24)) ? CHECK : DATA;
        DATA:    if (acc) state_nx = (cnt_dec == '0) ? DONE :
                                     (req_q && cnt_dec == CNT_W'(24)) ? CHECK : DATA;
        CHECK:   if (acc && cnt_dec == '0) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = state;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lfsr      <= '0;
      req_q     <= 1'b0;
      err_proto <= 1'b0;
      out_wreq  <= 1'b0;
      out_data  <= 1'b0;
    end else begin
      state    <= state_nx;
      out_wreq <= wr;
      out_data <= wr & in_data;
      if (in_start) begin
        cnt       <= k_sel;
        req_q     <= in_req_crc;
        lfsr      <= '0;
        err_proto <= (state != IDLE);
      end else begin
        if (acc) cnt <= cnt_dec;
        if (feed) lfsr <= lfsr_nx;
        if (bad) err_proto <= 1'b1;
      end
    end
  end
`ifdef CB_DESEG_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt     <= '0;
      crc_err_cnt <= '0;
    end else if (blk_done) begin
      blk_cnt     <= blk_cnt + 16'd1;
      crc_err_cnt <= crc_err_cnt + {15'd0, ~crc_ok};
    end
  end
`endif
endmodule

// File: tb/tb_cb_desegment.sv
// tb_cb_desegment: scoreboard bench for cb_desegment (payload order, CRC verdict, framing errors, reset)
module tb_cb_desegment;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_start = 1'b0, in_block_size = 1'b0, in_req_crc = 1'b0, in_valid = 1'b0;
  logic in_data = 1'b0, in_filling = 1'b0, in_crc = 1'b0, out_full = 1'b0;
  logic in_ready, out_wreq, out_data, blk_done, crc_ok, err_proto;
`ifdef CB_DESEG_STATS_EN
  logic [15:0] blk_cnt, crc_err_cnt;
`endif
  typedef struct packed {logic ok; logic err;} done_t;
  logic exp_q[$];
  done_t done_q[$];
  int checks = 0, failures = 0;
  int exp_blk = 0, exp_crc_err = 0;
  logic chk_wr = 1'b1, tog_en = 1'b0;

  cb_desegment dut (
    .clk(clk), .reset_n(reset_n), .in_start(in_start), .in_block_size(in_block_size),
    .in_req_crc(in_req_crc), .in_valid(in_valid), .in_data(in_data), .in_filling(in_filling),
    .in_crc(in_crc), .in_ready(in_ready), .out_full(out_full), .out_wreq(out_wreq),
    .out_data(out_data), .blk_done(blk_done), .crc_ok(crc_ok), .err_proto(err_proto)
`ifdef CB_DESEG_STATS_EN
    , .blk_cnt(blk_cnt), .crc_err_cnt(crc_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] crc24(input logic q[$]);
    logic [23:0] r;
    logic fb;
    r = '0;
    foreach (q[i]) begin
      fb = r[23] ^ q[i];
      r = {r[22:0], 1'b0} ^ (fb ? 24'h800063 : 24'h0);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (out_full) chk("ready_while_full", {31'd0, in_ready}, 32'd0);
      if (out_wreq && chk_wr) begin
        if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else chk("out_data", {31'd0, out_data}, {31'd0, exp_q.pop_front()});
      end
      if (blk_done) begin
        if (done_q.size() == 0) chk("unexpected_blk_done", 32'd1, 32'd0);
        else begin
          done_t e;
          e = done_q.pop_front();
          chk("crc_ok", {31'd0, crc_ok}, {31'd0, e.ok});
          chk("err_proto_at_done", {31'd0, err_proto}, {31'd0, e.err});
          exp_blk++;
          if (!e.ok) exp_crc_err++;
        end
      end
    end
  end

  initial begin
    int c3;
    c3 = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) begin
        c3++;
        if (c3 == 3) begin
          out_full = ~out_full;
          c3 = 0;
        end
      end else out_full = 1'b0;
    end
  end

  task automatic send_bit(input logic d, input logic f, input logic c);
    int n;
    in_valid = 1'b1; in_data = d; in_filling = f; in_crc = c;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic start_blk(input logic bs, input logic rc);
    in_valid = 1'b0; in_start = 1'b1; in_block_size = bs; in_req_crc = rc;
    @(posedge clk); #1;
    in_start = 1'b0;
  endtask

  task automatic finish_blk();
    in_valid = 1'b0; in_filling = 1'b0; in_crc = 1'b0;
    @(posedge clk); #1;
    chk("writes_drained", exp_q.size(), 32'd0);
    chk("done_seen", done_q.size(), 32'd0);
  endtask

  task automatic run_block(input logic bs, input logic rc, input int nfill, input logic pl[$], input logic flip);
    logic [23:0] c;
    done_t e;
    start_blk(bs, rc);
    chk("err_cleared_at_start", {31'd0, err_proto}, 32'd0);
    e.ok = ~(rc & flip); e.err = 1'b0;
    done_q.push_back(e);
    for (int i = 0; i < nfill; i++) send_bit(1'b0, 1'b1, 1'b0);
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
      send_bit(pl[i], 1'b0, 1'b0);
    end
    if (rc) begin
      c = crc24(pl);
      if (flip) c[5] = ~c[5];
      for (int i = 23; i >= 0; i--) send_bit(c[i], 1'b0, 1'b1);
    end
    finish_blk();
  endtask

  task automatic rand_pl(input int n, output logic q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic chk_stats();
`ifdef CB_DESEG_STATS_EN
    chk("blk_cnt", {16'd0, blk_cnt}, exp_blk);
    chk("crc_err_cnt", {16'd0, crc_err_cnt}, exp_crc_err);
`endif
  endtask

  initial begin
    #50000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pl[$];
    logic [7:0] pat;
    done_t e;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_wreq", {31'd0, out_wreq}, 32'd0);
    chk("rst_blk_done", {31'd0, blk_done}, 32'd0);
    chk("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
    chk("rst_err_proto", {31'd0, err_proto}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    pat = 8'hA5;
    pl.delete();
    for (int i = 0; i < 1024; i++) pl.push_back(pat[7 - (i % 8)]);
    run_block(1'b0, 1'b0, 32, pl, 1'b0);
    chk("err_after_clean", {31'd0, err_proto}, 32'd0);

    rand_pl(6120, pl);
    run_block(1'b1, 1'b1, 0, pl, 1'b0);
    rand_pl(6120, pl);
    run_block(1'b1, 1'b1, 0, pl, 1'b1);
    chk_stats();

    tog_en = 1'b1;
    rand_pl(1056, pl);
    run_block(1'b0, 1'b0, 0, pl, 1'b0);
    tog_en = 1'b0;
    @(posedge clk); #1;

    start_blk(1'b1, 1'b0);
    rand_pl(500, pl);
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
      send_bit(pl[i], 1'b0, 1'b0);
    end
    start_blk(1'b0, 1'b0);
    chk("err_on_abort", {31'd0, err_proto}, 32'd1);
    e.ok = 1'b1; e.err = 1'b1;
    done_q.push_back(e);
    rand_pl(1056, pl);
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
      send_bit(pl[i], 1'b0, 1'b0);
    end
    finish_blk();
    rand_pl(1024, pl);
    run_block(1'b0, 1'b1, 8, pl, 1'b0);

    start_blk(1'b0, 1'b0);
    chk_wr = 1'b0;
    e.ok = 1'b1; e.err = 1'b1;
    done_q.push_back(e);
    for (int i = 0; i < 1056; i++) begin
      send_bit(1'($urandom_range(0, 1)), i == 100, i == 200);
      if (i == 150) chk("err_filling_in_data", {31'd0, err_proto}, 32'd1);
    end
    in_valid = 1'b0; in_filling = 1'b0; in_crc = 1'b0;
    @(posedge clk); #1;
    chk("done_after_err_blk", done_q.size(), 32'd0);
    chk_wr = 1'b1;
    chk_stats();

    start_blk(1'b0, 1'b1);
    rand_pl(1032, pl);
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
      send_bit(pl[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b0, 1'b1);
    in_valid = 1'b0; in_crc = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_out_wreq", {31'd0, out_wreq}, 32'd0);
    chk("mid_rst_out_data", {31'd0, out_data}, 32'd0);
    chk("mid_rst_blk_done", {31'd0, blk_done}, 32'd0);
    chk("mid_rst_crc_ok", {31'd0, crc_ok}, 32'd0);
    chk("mid_rst_err_proto", {31'd0, err_proto}, 32'd0);
    chk("mid_rst_writes_drained", exp_q.size(), 32'd0);
    exp_blk = 0; exp_crc_err = 0;
    chk_stats();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    rand_pl(1032, pl);
    run_block(1'b0, 1'b1, 0, pl, 1'b0);
    chk_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
